// File: rtl/can_pkg.sv
// Shared CAN definitions: bit levels, destuffer states and default timing lengths.
package can_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        FRAME     = 2'd2
    } state_t;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    localparam int DEFAULT_STUFF_LEN = 5;
    localparam int DEFAULT_IDLE_LEN  = 11;

endpackage

// File: rtl/can_bit_destuffer_if.sv
// Bit-stream link between the bit sampler / frame decoder and the destuffer.
interface can_bit_destuffer_if;
    logic sample_valid;
    logic sample_bit;
    logic stuff_en;
    logic out_valid;
    logic out_bit;
    logic sof;
    logic stuff_err;
    logic bus_idle;

    modport master (
        output sample_valid, sample_bit, stuff_en,
        input  out_valid, out_bit, sof, stuff_err, bus_idle
    );

    modport slave (
        input  sample_valid, sample_bit, stuff_en,
        output out_valid, out_bit, sof, stuff_err, bus_idle
    );
endinterface

// File: rtl/can_bit_destuffer.sv
// Removes CAN stuff bits from the sampled bit stream, flags stuff violations
// and tracks bus integration / idle detection.
module can_bit_destuffer
    import can_pkg::*;
#(
    parameter int STUFF_LEN = DEFAULT_STUFF_LEN,
    parameter int IDLE_LEN  = DEFAULT_IDLE_LEN
) (
    input  logic               clk,
    input  logic               rst,
    can_bit_destuffer_if.slave bus
);

    localparam int              REC_W     = $clog2(IDLE_LEN + 1);
    localparam logic [REC_W-1:0] IDLE_MAX  = REC_W'(IDLE_LEN);
    localparam logic [2:0]      STUFF_MAX = 3'(STUFF_LEN);

    state_t           state_reg, state_next;
    logic [2:0]       run_len_reg, run_len_next;
    logic             last_bit_reg, last_bit_next;
    logic [REC_W-1:0] rec_cnt_reg, rec_cnt_next;
    logic             out_valid_reg, out_valid_next;
    logic             out_bit_reg, out_bit_next;
    logic             sof_reg, sof_next;
    logic             stuff_err_reg, stuff_err_next;
    logic             bus_idle_reg, bus_idle_next;

    logic [REC_W-1:0] rec_inc;
    logic             rec_hit;
    logic             same_bit;
    logic [2:0]       run_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= WAIT_IDLE;
            run_len_reg   <= 3'd0;
            last_bit_reg  <= CAN_RECESSIVE;
            rec_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_bit_reg   <= CAN_RECESSIVE;
            sof_reg       <= 1'b0;
            stuff_err_reg <= 1'b0;
            bus_idle_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            run_len_reg   <= run_len_next;
            last_bit_reg  <= last_bit_next;
            rec_cnt_reg   <= rec_cnt_next;
            out_valid_reg <= out_valid_next;
            out_bit_reg   <= out_bit_next;
            sof_reg       <= sof_next;
            stuff_err_reg <= stuff_err_next;
            bus_idle_reg  <= bus_idle_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        run_len_next   = run_len_reg;
        last_bit_next  = last_bit_reg;
        rec_cnt_next   = rec_cnt_reg;
        out_valid_next = 1'b0;
        out_bit_next   = out_bit_reg;
        sof_next       = 1'b0;
        stuff_err_next = 1'b0;
        bus_idle_next  = bus_idle_reg;

        rec_inc  = (rec_cnt_reg == IDLE_MAX) ? rec_cnt_reg : rec_cnt_reg + REC_W'(1);
        rec_hit  = (bus.sample_bit == CAN_RECESSIVE) && (rec_inc == IDLE_MAX);
        same_bit = (bus.sample_bit == last_bit_reg);
        run_step = !same_bit ? 3'd1 : ((run_len_reg == 3'd7) ? 3'd7 : run_len_reg + 3'd1);

        if (bus.sample_valid) begin
            rec_cnt_next = (bus.sample_bit == CAN_RECESSIVE) ? rec_inc : '0;

            case (state_reg)
                WAIT_IDLE: begin
                    if (rec_hit) begin
                        state_next    = IDLE;
                        bus_idle_next = 1'b1;
                    end
                end

                IDLE: begin
                    if (bus.sample_bit == CAN_DOMINANT) begin
                        out_valid_next = 1'b1;
                        out_bit_next   = CAN_DOMINANT;
                        sof_next       = 1'b1;
                        bus_idle_next  = 1'b0;
                        run_len_next   = 3'd1;
                        last_bit_next  = CAN_DOMINANT;
                        state_next     = FRAME;
                    end
                end

                FRAME: begin
                    // A run left long by the unstuffed tail still counts as a stuff position.
                    if (bus.stuff_en && (run_len_reg >= STUFF_MAX)) begin
                        if (!same_bit) begin
                            run_len_next  = 3'd1;
                            last_bit_next = bus.sample_bit;
                        end else begin
                            stuff_err_next = 1'b1;
                            state_next     = WAIT_IDLE;
                            rec_cnt_next   = REC_W'(bus.sample_bit);
                        end
                    end else begin
                        out_valid_next = 1'b1;
                        out_bit_next   = bus.sample_bit;
                        run_len_next   = run_step;
                        last_bit_next  = bus.sample_bit;
                        if (!bus.stuff_en && rec_hit) begin
                            state_next    = IDLE;
                            bus_idle_next = 1'b1;
                        end
                    end
                end

                default: state_next = WAIT_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_bit   = out_bit_reg;
    assign bus.sof       = sof_reg;
    assign bus.stuff_err = stuff_err_reg;
    assign bus.bus_idle  = bus_idle_reg;

endmodule
